// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared state encoding and delay-counter sizing for the SPI transaction sequencer.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_FETCH,
    ST_XFER,
    ST_GAP,
    ST_CS_HOLD,
    ST_CS_IDLE
  } spi_ctrl_state_t;

  function automatic int max_delay(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // The counter is loaded with N-1, so it only has to hold values up to max-1.
  function automatic int dly_cnt_width(input int max_cycles);
    return (max_cycles <= 2) ? 1 : $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_delay_cnt.sv
// Loadable down-counter shared by the setup, gap, hold and idle phases.
module spi_delay_cnt #(
  parameter int Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Sequences multi-byte SPI commands: chip-select timing plus one-byte-at-a-time
// hand-off to the spi_host byte engine.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int NumCs         = 2,
  parameter int LenWidth      = 8,
  parameter int CsSetupCycles = 4,
  parameter int CsHoldCycles  = 4,
  parameter int CsIdleCycles  = 8,
  parameter int GapCycles     = 0,
  localparam int CsIdxWidth   = (NumCs > 1) ? $clog2(NumCs) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [LenWidth-1:0]   cmd_len_i,
  input  logic [CsIdxWidth-1:0] cmd_cs_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [7:0]            tx_data_i,
  output logic                  rx_valid_o,
  output logic [7:0]            rx_data_o,
  output logic                  rx_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [NumCs-1:0]      cs_no,
  output logic                  host_start_o,
  output logic [7:0]            host_tx_byte_o,
  input  logic [7:0]            host_rx_byte_i,
  input  logic                  host_byte_done_i
);

  localparam int MaxDly   = max_delay(CsSetupCycles, CsHoldCycles, CsIdleCycles, GapCycles);
  localparam int DlyWidth = dly_cnt_width(MaxDly);

  localparam logic [DlyWidth-1:0] SetupLoad = DlyWidth'(CsSetupCycles - 1);
  localparam logic [DlyWidth-1:0] HoldLoad  = DlyWidth'(CsHoldCycles - 1);
  localparam logic [DlyWidth-1:0] IdleLoad  = DlyWidth'(CsIdleCycles - 1);
  localparam logic [DlyWidth-1:0] GapLoad   = DlyWidth'((GapCycles > 0) ? GapCycles - 1 : 0);

  spi_ctrl_state_t      state_q;
  logic [LenWidth-1:0]  remaining_q;
  logic                 done_prev_q;
  logic                 done_rise;
  logic                 last_byte;
  logic [NumCs-1:0]     cs_sel_n;
  logic                 dly_load;
  logic [DlyWidth-1:0]  dly_val;
  logic                 dly_en;
  logic                 dly_done;

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign tx_ready_o  = (state_q == ST_FETCH);
  assign done_rise   = host_byte_done_i && !done_prev_q;
  assign last_byte   = (remaining_q == '0);
  assign dly_en      = (state_q == ST_CS_SETUP) || (state_q == ST_GAP) ||
                       (state_q == ST_CS_HOLD)  || (state_q == ST_CS_IDLE);

  // Out-of-range indices leave every select high; the bytes still go out.
  always_comb begin
    cs_sel_n = '1;
    for (int i = 0; i < NumCs; i++) begin
      if (cmd_cs_i == CsIdxWidth'(i)) cs_sel_n[i] = 1'b0;
    end
  end

  // Each timed state is entered with the counter preloaded to N-1, giving N cycles.
  always_comb begin
    dly_load = 1'b0;
    dly_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          dly_load = 1'b1;
          dly_val  = SetupLoad;
        end
      end
      ST_XFER: begin
        if (done_rise) begin
          if (last_byte) begin
            dly_load = 1'b1;
            dly_val  = HoldLoad;
          end else if (GapCycles > 0) begin
            dly_load = 1'b1;
            dly_val  = GapLoad;
          end
        end
      end
      ST_CS_HOLD: begin
        if (dly_done) begin
          dly_load = 1'b1;
          dly_val  = IdleLoad;
        end
      end
      default: ;
    endcase
  end

  spi_delay_cnt #(
    .Width (DlyWidth)
  ) u_delay_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (dly_load),
    .load_val_i (dly_val),
    .en_i       (dly_en),
    .done_o     (dly_done)
  );

  // Dropping host_start_o on the done edge keeps spi_host from relaunching the byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      remaining_q    <= '0;
      done_prev_q    <= 1'b0;
      cs_no          <= '1;
      host_start_o   <= 1'b0;
      host_tx_byte_o <= '0;
      rx_valid_o     <= 1'b0;
      rx_data_o      <= '0;
      rx_last_o      <= 1'b0;
      done_o         <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      done_prev_q <= host_byte_done_i;
      rx_valid_o  <= 1'b0;
      rx_last_o   <= 1'b0;
      done_o      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            remaining_q <= cmd_len_i;
            cs_no       <= cs_sel_n;
            busy_o      <= 1'b1;
            state_q     <= ST_CS_SETUP;
          end
        end
        ST_CS_SETUP: begin
          if (dly_done) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (tx_valid_i) begin
            host_tx_byte_o <= tx_data_i;
            host_start_o   <= 1'b1;
            state_q        <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (done_rise) begin
            rx_data_o    <= host_rx_byte_i;
            rx_valid_o   <= 1'b1;
            rx_last_o    <= last_byte;
            host_start_o <= 1'b0;
            if (last_byte) begin
              state_q <= ST_CS_HOLD;
            end else begin
              remaining_q <= remaining_q - LenWidth'(1);
              state_q     <= (GapCycles > 0) ? ST_GAP : ST_FETCH;
            end
          end
        end
        ST_GAP: begin
          if (dly_done) state_q <= ST_FETCH;
        end
        ST_CS_HOLD: begin
          if (dly_done) begin
            cs_no   <= '1;
            done_o  <= 1'b1;
            state_q <= ST_CS_IDLE;
          end
        end
        ST_CS_IDLE: begin
          if (dly_done) begin
            busy_o  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: behavioural byte engine, TX feeder,
// RX scoreboard, vector table, corner-case sequences and randomized commands.
module tb_spi_xfer_ctrl;

  localparam int NumCs         = 2;
  localparam int CsSetupCycles = 4;
  localparam int CsHoldCycles  = 4;
  localparam int CsIdleCycles  = 8;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } rx_exp_t;

  typedef struct {
    logic [0:0] cs;
    int         nbytes;
    logic [1:0] expMask;
    int         expLaunch;
    int         expLast;
    int         expDone;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_len = '0;
  logic [0:0] cmd_cs = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = '0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_last;
  logic       busy;
  logic       done;
  logic [1:0] cs_n;
  logic       host_start;
  logic [7:0] host_tx_byte;
  logic [7:0] host_rx_byte = '0;
  logic       host_done = 1'b0;

  int totalChecks = 0;
  int passChecks  = 0;

  // Engine behaviour knobs
  bit engRandom  = 1'b0;
  int engLatency = 2;
  int engHold    = 1;

  // TX feeder state
  logic [7:0] txQ[$];
  bit  randStall = 1'b0;
  int  stallIdx  = -1;
  int  stallLen  = 0;
  int  stallLeft = 0;
  int  txPopped  = 0;
  bit  hsPending = 1'b0;

  // Scoreboard and per-command observations
  rx_exp_t    expRx[$];
  int         cyc = 0;
  int         cmdLaunch, cmdRx, cmdLast, cmdDone, csFalls;
  logic [1:0] csMask;
  logic [7:0] lastRxData;
  int         tCsFall, tCsRise, tFirstStart, tLastRx, tDone, lastHighRun;
  bit         stallWatch = 1'b0;
  int         stallFetch, stallViol;
  bit         busyWatch = 1'b0;
  int         readyViol;

  vec_t vecs[6];

  spi_xfer_ctrl #(
    .NumCs         (NumCs),
    .LenWidth      (8),
    .CsSetupCycles (CsSetupCycles),
    .CsHoldCycles  (CsHoldCycles),
    .CsIdleCycles  (CsIdleCycles),
    .GapCycles     (0)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .cmd_valid_i      (cmd_valid),
    .cmd_ready_o      (cmd_ready),
    .cmd_len_i        (cmd_len),
    .cmd_cs_i         (cmd_cs),
    .tx_valid_i       (tx_valid),
    .tx_ready_o       (tx_ready),
    .tx_data_i        (tx_data),
    .rx_valid_o       (rx_valid),
    .rx_data_o        (rx_data),
    .rx_last_o        (rx_last),
    .busy_o           (busy),
    .done_o           (done),
    .cs_no            (cs_n),
    .host_start_o     (host_start),
    .host_tx_byte_o   (host_tx_byte),
    .host_rx_byte_i   (host_rx_byte),
    .host_byte_done_i (host_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual === expected) passChecks++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
  endtask

  // Byte engine: after a launch it answers tx^0x99 and raises done for a while.
  initial begin
    logic [7:0] txb;
    int lat, hold;
    forever begin
      @(negedge clk);
      if (rst_n && host_start) begin
        txb  = host_tx_byte;
        lat  = engRandom ? int'($urandom_range(1, 4)) : engLatency;
        hold = engRandom ? int'($urandom_range(1, 6)) : engHold;
        repeat (lat) @(negedge clk);
        host_rx_byte = txb ^ 8'h99;
        host_done    = 1'b1;
        @(negedge clk);
        if (rst_n) checkOutput("start_drop_after_done", host_start, 0);
        repeat (hold - 1) @(negedge clk);
        host_done = 1'b0;
      end
    end
  end

  // TX feeder with optional forced or random stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (hsPending) begin
        void'(txQ.pop_front());
        txPopped++;
        if (txPopped == stallIdx) stallLeft = stallLen;
      end
      if (stallLeft > 0) begin
        stallLeft--;
        tx_valid = 1'b0;
      end else if (txQ.size() > 0 && !(randStall && $urandom_range(0, 3) == 0)) begin
        tx_valid = 1'b1;
        tx_data  = txQ[0];
      end else begin
        tx_valid = 1'b0;
      end
      hsPending = tx_valid && tx_ready && rst_n;
    end
  end

  // Monitor: scoreboard RX bytes and record CS/launch/done timing.
  initial begin
    logic [1:0] prevCs;
    logic       prevStart;
    rx_exp_t    e;
    prevCs    = 2'b11;
    prevStart = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rx_valid) begin
        cmdRx++;
        lastRxData = rx_data;
        if (rx_last) begin
          cmdLast++;
          tLastRx = cyc;
        end
        if (expRx.size() == 0) begin
          checkOutput("rx_unexpected", 1, 0);
        end else begin
          e = expRx.pop_front();
          checkOutput("rx_data", rx_data, e.data);
          checkOutput("rx_last", rx_last, e.last);
        end
      end
      if (host_start && !prevStart) begin
        cmdLaunch++;
        if (cmdLaunch == 1) tFirstStart = cyc;
      end
      if (prevCs == 2'b11 && cs_n != 2'b11) begin
        csFalls++;
        tCsFall     = cyc;
        lastHighRun = cyc - tCsRise;
      end
      if (prevCs != 2'b11 && cs_n == 2'b11) tCsRise = cyc;
      csMask = csMask | ~cs_n;
      if (done) begin
        cmdDone++;
        tDone = cyc;
      end
      if (stallWatch && tx_ready) begin
        stallFetch++;
        if (host_start || cs_n[0]) stallViol++;
      end
      if (busyWatch && busy && cmd_ready) readyViol++;
      prevCs    = cs_n;
      prevStart = host_start;
    end
  end

  task automatic clearStats();
    cmdLaunch = 0; cmdRx = 0; cmdLast = 0; cmdDone = 0; csFalls = 0;
    csMask = 2'b00; stallFetch = 0; stallViol = 0; readyViol = 0; txPopped = 0;
  endtask

  task automatic pushCommand(input int nbytes, input bit useFirst, input logic [7:0] firstByte);
    logic [7:0] b;
    rx_exp_t    e;
    for (int i = 0; i < nbytes; i++) begin
      b = (i == 0 && useFirst) ? firstByte : 8'($urandom);
      txQ.push_back(b);
      e.data = b ^ 8'h99;
      e.last = (i == nbytes - 1);
      expRx.push_back(e);
    end
  endtask

  task automatic waitAccept();
    int n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_accept", cmd_ready, 1);
    @(negedge clk);
  endtask

  task automatic waitDone();
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", done, 1);
  endtask

  task automatic applyStimulus(input logic [0:0] cs, input int nbytes, input bit useFirst,
                               input logic [7:0] firstByte);
    clearStats();
    pushCommand(nbytes, useFirst, firstByte);
    cmd_valid = 1'b1;
    cmd_len   = 8'(nbytes - 1);
    cmd_cs    = cs;
    waitAccept();
    cmd_valid = 1'b0;
    waitDone();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{cs: 1'b0, nbytes: 2,   expMask: 2'b01, expLaunch: 2,   expLast: 1, expDone: 1};
    vecs[1] = '{cs: 1'b1, nbytes: 4,   expMask: 2'b10, expLaunch: 4,   expLast: 1, expDone: 1};
    vecs[2] = '{cs: 1'b1, nbytes: 1,   expMask: 2'b10, expLaunch: 1,   expLast: 1, expDone: 1};
    vecs[3] = '{cs: 1'b0, nbytes: 5,   expMask: 2'b01, expLaunch: 5,   expLast: 1, expDone: 1};
    vecs[4] = '{cs: 1'b0, nbytes: 256, expMask: 2'b01, expLaunch: 256, expLast: 1, expDone: 1};
    vecs[5] = '{cs: 1'b1, nbytes: 3,   expMask: 2'b10, expLaunch: 3,   expLast: 1, expDone: 1};

    clearStats();
    repeat (3) @(negedge clk);
    checkOutput("reset_cs_n", cs_n, 2'b11);
    checkOutput("reset_host_start", host_start, 0);
    checkOutput("reset_host_tx_byte", host_tx_byte, 0);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_rx_last", rx_last, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_cmd_ready", cmd_ready, 1);
    checkOutput("reset_tx_ready", tx_ready, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single byte on cs0");
    applyStimulus(1'b0, 1, 1'b1, 8'hA5);
    checkOutput("single_rx_data", lastRxData, 8'h3C);
    checkOutput("single_cs_mask", csMask, 2'b01);
    checkOutput("single_launches", cmdLaunch, 1);
    checkOutput("single_rx_last", cmdLast, 1);
    checkOutput("single_done_pulses", cmdDone, 1);
    checkOutput("single_setup_to_launch", tFirstStart - tCsFall, CsSetupCycles + 1);
    checkOutput("single_last_rx_to_cs_high", tCsRise - tLastRx, CsHoldCycles);
    checkOutput("single_done_with_cs_high", tDone, tCsRise);

    $display("[TB] vector table");
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].cs, vecs[v].nbytes, 1'b0, 8'h00);
      checkOutput("vec_cs_mask", csMask, vecs[v].expMask);
      checkOutput("vec_cs_falls", csFalls, 1);
      checkOutput("vec_launches", cmdLaunch, vecs[v].expLaunch);
      checkOutput("vec_rx_count", cmdRx, vecs[v].nbytes);
      checkOutput("vec_rx_last", cmdLast, vecs[v].expLast);
      checkOutput("vec_done", cmdDone, vecs[v].expDone);
      checkOutput("vec_sb_empty", expRx.size(), 0);
    end

    $display("[TB] tx stall before byte 2");
    stallIdx   = 1;
    stallLen   = 50;
    stallWatch = 1'b1;
    applyStimulus(1'b0, 3, 1'b0, 8'h00);
    stallWatch = 1'b0;
    stallIdx   = -1;
    checkOutput("stall_observed", stallFetch >= 40, 1);
    checkOutput("stall_violations", stallViol, 0);
    checkOutput("stall_rx_count", cmdRx, 3);
    checkOutput("stall_launches", cmdLaunch, 3);
    checkOutput("stall_cs_falls", csFalls, 1);

    $display("[TB] done held high");
    engHold = 6;
    applyStimulus(1'b1, 3, 1'b0, 8'h00);
    engHold = 1;
    checkOutput("held_rx_count", cmdRx, 3);
    checkOutput("held_launches", cmdLaunch, 3);
    checkOutput("held_rx_last", cmdLast, 1);

    $display("[TB] command valid held through busy");
    repeat (20) @(negedge clk);
    clearStats();
    pushCommand(2, 1'b0, 8'h00);
    pushCommand(1, 1'b0, 8'h00);
    cmd_valid = 1'b1;
    cmd_len   = 8'd1;
    cmd_cs    = 1'b0;
    waitAccept();
    cmd_len   = 8'd0;
    cmd_cs    = 1'b1;
    busyWatch = 1'b1;
    begin
      int n = 0;
      while (!cmd_ready && n < 400) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("held_cmd_ready_returns", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    busyWatch = 1'b0;
    waitDone();
    repeat (2) @(negedge clk);
    checkOutput("held_ready_while_busy", readyViol, 0);
    checkOutput("held_cs_high_run", lastHighRun, CsIdleCycles + 1);
    checkOutput("held_cs_mask", csMask, 2'b11);
    checkOutput("held_done_count", cmdDone, 2);
    checkOutput("held_launch_count", cmdLaunch, 3);

    $display("[TB] reset during third byte");
    engLatency = 3;
    clearStats();
    pushCommand(4, 1'b0, 8'h00);
    cmd_valid = 1'b1;
    cmd_len   = 8'd3;
    cmd_cs    = 1'b1;
    waitAccept();
    cmd_valid = 1'b0;
    begin
      int n = 0;
      while (cmdLaunch < 3 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("rst_third_launch", cmdLaunch >= 3, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_cs_n", cs_n, 2'b11);
    checkOutput("rst_async_start", host_start, 0);
    checkOutput("rst_async_busy", busy, 0);
    repeat (3) @(negedge clk);
    txQ.delete();
    expRx.delete();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("rst_no_done", cmdDone, 0);
    engLatency = 2;
    applyStimulus(1'b1, 2, 1'b0, 8'h00);
    checkOutput("post_rst_launches", cmdLaunch, 2);
    checkOutput("post_rst_done", cmdDone, 1);
    checkOutput("post_rst_cs_mask", csMask, 2'b10);

    $display("[TB] randomized commands");
    engRandom = 1'b1;
    randStall = 1'b1;
    for (int r = 0; r < 12; r++) begin
      logic [0:0] rcs;
      int         rn;
      rcs = 1'($urandom_range(0, 1));
      rn  = int'($urandom_range(1, 6));
      applyStimulus(rcs, rn, 1'b0, 8'h00);
      checkOutput("rand_launches", cmdLaunch, rn);
      checkOutput("rand_done", cmdDone, 1);
      checkOutput("rand_rx_last", cmdLast, 1);
      checkOutput("rand_cs_mask", csMask, 2'b01 << rcs);
    end
    engRandom = 1'b0;
    randStall = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("final_sb_empty", expRx.size(), 0);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
